// File: rtl/vrf_bank_read_responder.sv
// VRF bank read responder: round-robin read grant over NPORTS pipes, two-cycle read
// latency, one write port with priority. Optional write-starvation guard: VRF_WRITE_STARVE_GUARD_EN.
module vrf_bank_read_responder #(
  parameter int NPORTS       = 2,
  parameter int DEPTH        = 256,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [NPORTS-1:0]     req_valid,
  output logic [NPORTS-1:0]     req_ready,
  input  logic [5*NPORTS-1:0]   req_vs,
  input  logic [3*NPORTS-1:0]   req_offset,
  input  logic [2*NPORTS-1:0]   req_readSource,
  input  logic [3*NPORTS-1:0]   req_instructionIndex,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [4:0]            wr_vs,
  input  logic [2:0]            wr_offset,
  input  logic [31:0]           wr_data,
  input  logic [3:0]            wr_mask,
  output logic [31:0]           rd_data,
  output logic [NPORTS-1:0]     rd_valid,
  output logic [1:0]            rd_readSource,
  output logic [2:0]            rd_instructionIndex
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = (NPORTS > 1) ? $clog2(NPORTS) : 1;

  logic [31:0]       mem [DEPTH];
  logic [PW-1:0]     lastGrant;
  logic [PW-1:0]     grantIdx;
  logic [PW-1:0]     cand;
  logic [NPORTS-1:0] grant;
  logic              found;
  logic              forceRead;
  logic              wrFire;
  logic              rdFire;

  logic              s1Valid;
  logic [AW-1:0]     s1Addr;
  logic [PW-1:0]     s1Port;
  logic [1:0]        s1Src;
  logic [2:0]        s1Idx;

  // Round-robin search starts at the port after the last granted one.
  always_comb begin
    grant    = '0;
    grantIdx = '0;
    cand     = '0;
    found    = 1'b0;
    for (int unsigned k = 1; k <= NPORTS; k++) begin
      cand = PW'((32'(lastGrant) + k) % NPORTS);
      if (!found && req_valid[cand]) begin
        found    = 1'b1;
        grantIdx = cand;
      end
    end
    if (found) grant[grantIdx] = 1'b1;
  end

`ifdef VRF_WRITE_STARVE_GUARD_EN
  localparam int CW = $clog2(STARVE_LIMIT + 1);
  logic [CW-1:0] starveCnt;

  assign forceRead = (starveCnt == CW'(STARVE_LIMIT));

  always_ff @(posedge clock) begin
    if (reset)
      starveCnt <= '0;
    else if (forceRead || rdFire || !(wrFire && |req_valid))
      starveCnt <= '0;
    else
      starveCnt <= starveCnt + 1'b1;
  end
`else
  logic unusedStarveLimit;
  assign unusedStarveLimit = (STARVE_LIMIT > 0);
  assign forceRead = 1'b0;
`endif

  assign wr_ready  = ~forceRead;
  assign wrFire    = wr_valid & wr_ready;
  assign req_ready = wrFire ? '0 : grant;
  assign rdFire    = |req_ready;

  always_ff @(posedge clock) begin
    if (!reset && wrFire) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (wr_mask[b]) mem[AW'({wr_vs, wr_offset})][8*b +: 8] <= wr_data[8*b +: 8];
      end
    end
  end

  // Stage 1 captures the granted request; stage 2 reads storage into the result bus.
  always_ff @(posedge clock) begin
    if (reset) begin
      lastGrant           <= PW'(NPORTS - 1);
      s1Valid             <= 1'b0;
      rd_valid            <= '0;
      rd_data             <= '0;
      rd_readSource       <= '0;
      rd_instructionIndex <= '0;
    end else begin
      s1Valid <= rdFire;
      if (rdFire) begin
        lastGrant <= grantIdx;
        s1Addr    <= AW'({req_vs[32'(grantIdx)*5 +: 5], req_offset[32'(grantIdx)*3 +: 3]});
        s1Port    <= grantIdx;
        s1Src     <= req_readSource[32'(grantIdx)*2 +: 2];
        s1Idx     <= req_instructionIndex[32'(grantIdx)*3 +: 3];
      end
      rd_valid <= '0;
      if (s1Valid) begin
        rd_valid[s1Port]    <= 1'b1;
        rd_data             <= mem[s1Addr];
        rd_readSource       <= s1Src;
        rd_instructionIndex <= s1Idx;
      end
    end
  end

endmodule

// File: tb/tb_vrf_bank_read_responder.sv
// Bench for vrf_bank_read_responder: directed scenarios plus random traffic against a
// memory/arbitration reference model; honours VRF_WRITE_STARVE_GUARD_EN when defined.
module tb_vrf_bank_read_responder;
  localparam int NP    = 2;
  localparam int LIMIT = 4;

  logic              clock = 1'b0;
  logic              reset;
  logic [NP-1:0]     req_valid;
  logic [NP-1:0]     req_ready;
  logic [5*NP-1:0]   req_vs;
  logic [3*NP-1:0]   req_offset;
  logic [2*NP-1:0]   req_readSource;
  logic [3*NP-1:0]   req_instructionIndex;
  logic              wr_valid;
  logic              wr_ready;
  logic [4:0]        wr_vs;
  logic [2:0]        wr_offset;
  logic [31:0]       wr_data;
  logic [3:0]        wr_mask;
  logic [31:0]       rd_data;
  logic [NP-1:0]     rd_valid;
  logic [1:0]        rd_readSource;
  logic [2:0]        rd_instructionIndex;

  vrf_bank_read_responder #(.NPORTS(NP), .DEPTH(256), .STARVE_LIMIT(LIMIT)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_vs(req_vs), .req_offset(req_offset),
    .req_readSource(req_readSource), .req_instructionIndex(req_instructionIndex),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_vs(wr_vs), .wr_offset(wr_offset),
    .wr_data(wr_data), .wr_mask(wr_mask),
    .rd_data(rd_data), .rd_valid(rd_valid), .rd_readSource(rd_readSource),
    .rd_instructionIndex(rd_instructionIndex)
  );

  always #5 clock = ~clock;

  typedef struct {
    int          due;
    int          port;
    logic [31:0] data;
    logic [1:0]  src;
    logic [2:0]  ii;
  } exp_t;

  int          checks = 0;
  int          errors = 0;
  exp_t        expq[$];
  logic [31:0] mem [256];
  int          mLast = NP - 1;
  int          mCnt = 0;
  int          cycN = 0;
  bit          prevReset = 1'b1;
  int          grantLog[$];
  logic [NP-1:0] obsReady;
  logic [NP-1:0] obsRdValid;
  logic [31:0]   obsRdData;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic setReq(input int p, input logic [4:0] vs, input logic [2:0] off,
                        input logic [1:0] src, input logic [2:0] ii);
    req_valid[p]               = 1'b1;
    req_vs[p*5 +: 5]           = vs;
    req_offset[p*3 +: 3]       = off;
    req_readSource[p*2 +: 2]   = src;
    req_instructionIndex[p*3 +: 3] = ii;
  endtask

  task automatic setWr(input logic [4:0] vs, input logic [2:0] off,
                       input logic [31:0] d, input logic [3:0] m);
    wr_valid = 1'b1; wr_vs = vs; wr_offset = off; wr_data = d; wr_mask = m;
  endtask

  task automatic idle();
    req_valid = '0;
    wr_valid  = 1'b0;
  endtask

  // One clock cycle: check outputs against the model, then advance the model.
  task automatic cyc();
    logic [NP-1:0] expReady;
    logic          expWr;
    logic [7:0]    a;
    int            gp;
    bit            fire;
    #1;
    expWr = 1'b1;
`ifdef VRF_WRITE_STARVE_GUARD_EN
    expWr = (mCnt != LIMIT);
`endif
    gp = -1;
    for (int k = 1; k <= NP; k++)
      if (gp < 0 && req_valid[(mLast + k) % NP]) gp = (mLast + k) % NP;
    expReady = '0;
    if (gp >= 0 && !(wr_valid && expWr)) expReady[gp] = 1'b1;
    chk("wr_ready", wr_ready, expWr);
    chk("req_ready", req_ready, expReady);
    obsReady = req_ready; obsRdValid = rd_valid; obsRdData = rd_data;

    if (expq.size() > 0 && expq[0].due == cycN) begin
      chk("rd_valid", rd_valid, 32'(1) << expq[0].port);
      chk("rd_data", rd_data, expq[0].data);
      chk("rd_readSource", rd_readSource, expq[0].src);
      chk("rd_instructionIndex", rd_instructionIndex, expq[0].ii);
      void'(expq.pop_front());
    end else begin
      chk("rd_valid_idle", rd_valid, 0);
      if (prevReset) begin
        chk("rst_rd_data", rd_data, 0);
        chk("rst_rd_readSource", rd_readSource, 0);
        chk("rst_rd_instructionIndex", rd_instructionIndex, 0);
      end
    end

    if (reset) begin
      expq.delete();
      mLast = NP - 1;
      mCnt  = 0;
    end else begin
      fire = (expReady != 0);
      if (fire) begin
        a = {req_vs[gp*5 +: 5], req_offset[gp*3 +: 3]};
        expq.push_back('{due: cycN + 2, port: gp, data: mem[a],
                         src: req_readSource[gp*2 +: 2], ii: req_instructionIndex[gp*3 +: 3]});
        mLast = gp;
        grantLog.push_back(gp);
      end
      if (wr_valid && expWr) begin
        a = {wr_vs, wr_offset};
        for (int b = 0; b < 4; b++)
          if (wr_mask[b]) mem[a][8*b +: 8] = wr_data[8*b +: 8];
      end
      if (!expWr || fire || !(wr_valid && expWr && req_valid != 0)) mCnt = 0;
      else mCnt++;
    end
    prevReset = reset;
    cycN++;
    @(negedge clock);
  endtask

  initial begin
    int grantAt[$];
    reset = 1'b1;
    req_valid = '0; req_vs = '0; req_offset = '0; req_readSource = '0; req_instructionIndex = '0;
    wr_valid = 1'b0; wr_vs = '0; wr_offset = '0; wr_data = '0; wr_mask = '0;
    @(posedge clock);
    @(negedge clock);
    cyc();
    reset = 1'b0;

    // Fill storage so every read has defined data.
    for (int i = 0; i < 256; i++) begin
      setWr(5'(i >> 3), 3'(i), $urandom, 4'hF);
      cyc();
    end
    idle();

    // Full write then a read of the same word.
    setWr(5'd3, 3'd5, 32'hDEADBEEF, 4'hF); cyc();
    idle(); setReq(0, 5'd3, 3'd5, 2'd2, 3'd5); cyc();
    idle(); cyc(); cyc();
    chk("deadbeef_valid", obsRdValid, 1);
    chk("deadbeef_data", obsRdData, 32'hDEADBEEF);

    // Make port 1 the last winner, then contend for 6 cycles.
    setReq(1, 5'd7, 3'd1, 2'd1, 3'd2); cyc();
    grantLog.delete();
    for (int i = 0; i < 6; i++) begin
      setReq(0, 5'(i), 3'(i), 2'(i), 3'(i));
      setReq(1, 5'(i + 10), 3'(7 - i), 2'(i + 1), 3'(i + 2));
      cyc();
    end
    idle(); cyc(); cyc();
    chk("alt_count", grantLog.size(), 6);
    for (int i = 0; i < 6 && i < grantLog.size(); i++) chk("alt_grant", grantLog[i], i % 2);

    // Partial-byte write; read fires the cycle right after.
    setWr(5'd9, 3'd2, 32'hAAAA_AAAA, 4'hF); cyc();
    setWr(5'd9, 3'd2, 32'h1234_5678, 4'h3); cyc();
    idle(); setReq(0, 5'd9, 3'd2, 2'd3, 3'd6); cyc();
    idle(); cyc(); cyc();
    chk("mask_data", obsRdData, 32'hAAAA_5678);

    // Write held for 10 cycles against a waiting port 1.
    idle(); cyc();
    for (int i = 0; i < 10; i++) begin
      setWr(5'd20, 3'(i), 32'(i) * 32'h0101_0101, 4'hF);
      setReq(1, 5'd4, 3'd4, 2'd0, 3'd1);
      cyc();
      if (obsReady[1]) grantAt.push_back(i);
    end
`ifdef VRF_WRITE_STARVE_GUARD_EN
    chk("starve_grants", grantAt.size(), 2);
    if (grantAt.size() == 2) begin
      chk("starve_first", grantAt[0], 4);
      chk("starve_second", grantAt[1], 9);
    end
`else
    chk("starve_grants", grantAt.size(), 0);
`endif
    wr_valid = 1'b0; cyc();
    chk("starve_release", obsReady, 2'b10);
    idle(); cyc(); cyc();

    // Fire at t, reset at t+1: result dropped and port 0 wins afterwards.
    setReq(0, 5'd3, 3'd5, 2'd1, 3'd3); cyc();
    idle(); setReq(1, 5'd3, 3'd5, 2'd1, 3'd3); reset = 1'b1; cyc();
    idle(); reset = 1'b0; cyc();
    chk("reset_drop", obsRdValid, 0);
    setReq(0, 5'd1, 3'd1, 2'd0, 3'd0); setReq(1, 5'd2, 3'd2, 2'd0, 3'd0); cyc();
    chk("reset_first_grant", obsReady, 2'b01);
    idle(); cyc(); cyc();

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      for (int p = 0; p < NP; p++) begin
        req_valid[p] = 1'($urandom);
        req_vs[p*5 +: 5] = 5'($urandom);
        req_offset[p*3 +: 3] = 3'($urandom);
        req_readSource[p*2 +: 2] = 2'($urandom);
        req_instructionIndex[p*3 +: 3] = 3'($urandom);
      end
      wr_valid = ($urandom_range(0, 3) == 0);
      wr_vs = 5'($urandom); wr_offset = 3'($urandom);
      wr_data = $urandom; wr_mask = 4'($urandom);
      reset = ($urandom_range(0, 99) == 0);
      cyc();
    end
    idle(); reset = 1'b0; cyc(); cyc(); cyc();
    chk("drain_empty", expq.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/vrf_bank_read_responder.md
# vrf_bank_read_responder

Responder side of the VRF read-request protocol. Accepts `{vs, offset, readSource, instructionIndex}` read requests from NPORTS read pipes and grants one per cycle using round-robin. It reads a 32-bit word from the bank's internal storage and returns the data exactly two cycles after the request handshake, which is the cycle in which a read pipe's two-stage fire pipeline samples the result. A single write port shares the storage and has priority over reads.

## Interface
- NPORTS, 2: number of read requesters (2..4).
- DEPTH, 256: words of storage; the address is `{vs, offset}`.
- STARVE_LIMIT, 4: consecutive write-blocked cycles before a read slot is forced (only with the macro).

- clock  in  1  clock; reset reset, synchronous, active-high; clock clock.
- reset  in  1  synchronous, active-high.
- req_valid  in  NPORTS  per-port request valid.
- req_ready  out  NPORTS  per-port grant; one-hot or zero.
- req_vs  in  5*NPORTS  register number.
- req_offset  in  3*NPORTS  word offset within the register.
- req_readSource  in  2*NPORTS  source tag, echoed back.
- req_instructionIndex  in  3*NPORTS  instruction tag, echoed back.
- wr_valid  in  1  write request.
- wr_ready  out  1  write accepted.
- wr_vs, wr_offset  in  5, 3  write address.
- wr_data  in  32  write data.
- wr_mask  in  4  byte enables.
- rd_data  out  32  read result, shared bus.
- rd_valid  out  NPORTS  one-hot; marks the port that owns rd_data this cycle.
- rd_readSource, rd_instructionIndex  out  2, 3  echoed tags, aligned with rd_data.

## Operation
- Fire: `req_valid[i] & req_ready[i]`. At most one fire per cycle.
- Arbitration: round-robin over ports whose `req_valid` is high, starting at `last_grant+1` mod NPORTS.
  - `last_grant` updates only on a fire.
  - Reset value of `last_grant` is NPORTS-1, so port 0 wins first.
- `req_ready[i]` is combinational from the current valids. It does not depend on any downstream ready: results cannot be back-pressured, and requesters guarantee sink space before asserting valid.
- Writes:
  - `wr_ready` = 1 except when a forced read slot is taken (macro only).
  - While `wr_valid & wr_ready`, every `req_ready` is 0.
  - Storage updates at the clock edge, per byte per `wr_mask`.
- Read pipeline:
  - Stage 1 registers the address, port index and tags at the fire.
  - Stage 2 registers the storage output into rd_data and sets `rd_valid[port]`.
- Read-after-write: a read that fires in the cycle after a write to the same address returns the new data. No same-cycle conflict exists because a write blocks reads.
- Storage is not reset. Reads of unwritten words return X/undefined.

## Timing
- Read fire at cycle t: rd_valid/rd_data at cycle t+2, valid for exactly one cycle.
- Back-to-back fires give back-to-back results, one per cycle. Peak throughput is 1 read/cycle.
- Write latency: visible to a read that fires at t+1 or later.
- Reset values: `rd_valid`=0, `rd_data`=0, `rd_readSource`=0, `rd_instructionIndex`=0, both pipeline valid bits=0, starvation counter=0.
  - `req_ready` and `wr_ready` follow the combinational rules during reset, but fires are ignored while reset is high.
- Reset mid-operation: in-flight stage-1/stage-2 reads are dropped (`rd_valid` goes to 0 next cycle), and `last_grant` returns to NPORTS-1.
- All ports idle: `req_ready`=0 and `last_grant` holds.
- A single requester holding valid is granted every cycle.

## Configuration
- `VRF_WRITE_STARVE_GUARD_EN` defined:
  - A counter increments each cycle in which `wr_valid` blocks at least one pending `req_valid`. It clears on any read fire or when no write is blocking.
  - When it reaches STARVE_LIMIT, the next cycle drives `wr_ready`=0, grants a read by normal round-robin, and clears the counter.
- Undefined: writes have strict priority, `wr_ready` is constant 1, and no counter is present.

## Test plan
- Write 0xDEADBEEF at vs=3, offset=5 (mask 0xF), then port 0 reads vs=3/off=5 at t → `rd_valid`=01 and `rd_data`=0xDEADBEEF at exactly t+2, tags echoed.
- Ports 0 and 1 both hold valid for 6 cycles → grants alternate 0,1,0,1,0,1; `rd_valid` alternates with a 2-cycle lag; no gaps.
- Write mask 0x3 of 0x1234_5678 over 0xAAAA_AAAA, then read → 0xAAAA_5678. A read that fires in the cycle right after the write sees the new value.
- `wr_valid` held for 10 cycles while port 1 is valid:
  - without the macro → zero grants until the write drops;
  - with the macro and STARVE_LIMIT=4 → `wr_ready`=0 and port 1 is granted in the 5th cycle, repeating every 5 cycles.
- Fire at t, assert reset at t+1 → no `rd_valid` at t+2, all outputs at reset values; after reset releases, port 0 wins the first contention.
- Randomized traffic against a reference memory model: every fire produces exactly one `rd_valid` 2 cycles later, to the correct port, with the correct data.
